fc1_ctrl: RTL and testbench

- Sequencer for the FC1 (400 -> 120) layer datapath.
- Walks the shared input-feature/weight address over all N_IN positions and drives the MAC-array clear and enable with read-latency alignment.
- Fires the single-cycle write-enable that latches bias-added results into the FC1 output registers, then signals completion.
- Sits between the top-level layer scheduler (start/done) and the FC1 MAC array plus output-register bank.

---
 rtl/fc1_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fc1_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc1_ctrl.sv
// fc1_ctrl: FC1 (400 -> 120) layer sequencer that walks the feature/weight address and drives MAC clear/enable and result capture.
// Defining FC1_PERF_CNT_EN adds the perf_cycles/perf_stalls per-pass counters.
module fc1_ctrl #(
    parameter int N_IN    = 400,
    parameter int ADDR_W  = 9,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] fc1_raddr,
    output logic              fc1_rd_en,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              f6_wr_en,
    output logic              f6_valid
`ifdef FC1_PERF_CNT_EN
    ,
    output logic [15:0]       perf_cycles,
    output logic [15:0]       perf_stalls
`endif
);

    localparam int DRAIN_N = RD_LAT + MAC_LAT;
    localparam int CNT_W   = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_IN - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_WB
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                rd_en_q, rd_en_d;
    logic                clr_q, clr_d;
    logic                wr_q, wr_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    drain_q, drain_d;
    logic [RD_LAT-1:0]   chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            raddr_q <= '0;
            rd_en_q <= 1'b0;
            clr_q   <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            rd_en_q <= rd_en_d;
            clr_q   <= clr_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            drain_q <= drain_d;
        end
    end

    // Outputs are computed for the state being entered, so every output is a flop.
    // raddr_q always shows the last issued address, so it doubles as the walk counter.
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        rd_en_d = 1'b0;
        clr_d   = 1'b0;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        valid_d = valid_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    clr_d   = 1'b1;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    raddr_d = '0;
                end
            end
            S_CLR: begin
                state_d = S_RUN;
                rd_en_d = 1'b1;
            end
            S_RUN: begin
                if (!in_stall) begin
                    if (raddr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LAST;
                    end else begin
                        raddr_d = raddr_q + ADDR_W'(1);
                        rd_en_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_WB;
                    wr_d    = 1'b1;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pure delay of the read strobe so stall bubbles reach the MACs unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= RD_LAT'({chain_q, rd_en_q});
        end
    end

`ifdef FC1_PERF_CNT_EN
    logic [15:0] cyc_q;
    logic [15:0] stl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                cyc_q <= '0;
                stl_q <= '0;
            end
        end else begin
            if (cyc_q != 16'hFFFF) begin
                cyc_q <= cyc_q + 16'd1;
            end
            if (state_q == S_RUN && in_stall && stl_q != 16'hFFFF) begin
                stl_q <= stl_q + 16'd1;
            end
        end
    end

    assign perf_cycles = cyc_q;
    assign perf_stalls = stl_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign fc1_raddr = raddr_q;
    assign fc1_rd_en = rd_en_q;
    assign mac_clr   = clr_q;
    assign mac_en    = chain_q[RD_LAT-1];
    assign f6_wr_en  = wr_q;
    assign f6_valid  = valid_q;

endmodule

// File: tb/tb_fc1_ctrl.sv
// tb_fc1_ctrl: directed bench for fc1_ctrl, checked every cycle against a pass-schedule model.
// A default instance and a small N_IN=4/RD_LAT=2/MAC_LAT=1 instance share one stimulus stream.
`timescale 1ns/1ps
module tb_fc1_ctrl;

    localparam int MAXC = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic in_stall = 1'b0;

    logic       aBusy, aDone, aRdEn, aClr, aMacEn, aWr, aValid;
    logic [8:0] aRaddr;
    logic       bBusy, bDone, bRdEn, bClr, bMacEn, bWr, bValid;
    logic [1:0] bRaddr;
`ifdef FC1_PERF_CNT_EN
    logic [15:0] aPc, aPs, bPc, bPs;
`endif

    fc1_ctrl dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .in_stall(in_stall),
        .busy(aBusy), .done(aDone), .fc1_raddr(aRaddr), .fc1_rd_en(aRdEn),
        .mac_clr(aClr), .mac_en(aMacEn), .f6_wr_en(aWr), .f6_valid(aValid)
`ifdef FC1_PERF_CNT_EN
        , .perf_cycles(aPc), .perf_stalls(aPs)
`endif
    );

    fc1_ctrl #(.N_IN(4), .ADDR_W(2), .RD_LAT(2), .MAC_LAT(1)) dutB (
        .clk(clk), .rst_n(rst_n), .start(start), .in_stall(in_stall),
        .busy(bBusy), .done(bDone), .fc1_raddr(bRaddr), .fc1_rd_en(bRdEn),
        .mac_clr(bClr), .mac_en(bMacEn), .f6_wr_en(bWr), .f6_valid(bValid)
`ifdef FC1_PERF_CNT_EN
        , .perf_cycles(bPc), .perf_stalls(bPs)
`endif
    );

    bit stStart[MAXC];
    bit stStall[MAXC];
    bit stRst[MAXC];

    int eRaddr[MAXC];
    bit eRchk[MAXC];
    bit eBusy[MAXC];
    bit eDone[MAXC];
    bit eRdEn[MAXC];
    bit eClr[MAXC];
    bit eMacEn[MAXC];
    bit eWr[MAXC];
    bit eValid[MAXC];
    int ePc[MAXC];
    int ePs[MAXC];
    bit ePerfChk[MAXC];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chkEn = 1'b0;
    int sel = 0;

    int doneCnt, doneCyc, macenCnt, clrCnt, clrCyc, wrCyc, firstMacen;
    int obsPc, obsPs;

    int  oRaddr;
    bit  oBusy, oDone, oRdEn, oClr, oMacEn, oWr, oValid;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic clearCycle(input int c);
        eRaddr[c] = 0;  eRchk[c] = 1'b1; eBusy[c] = 1'b0; eDone[c] = 1'b0;
        eRdEn[c] = 1'b0; eClr[c] = 1'b0;  eMacEn[c] = 1'b0; eWr[c] = 1'b0;
        eValid[c] = 1'b0; ePc[c] = 0; ePs[c] = 0; ePerfChk[c] = 1'b0;
    endtask

    // One pass accepted at cycle a: address k is issued one cycle after the previous
    // issue, plus one extra cycle for every stalled cycle in between.
    task automatic schedulePass(input int a, input int len, input int nin, input int rdl,
                                input int macl, output int doneAt);
        int t, u, wb, stalls;
        for (int j = a + 1; j < len; j++) clearCycle(j);
        if (a + 1 < len) begin
            eClr[a+1] = 1'b1; eBusy[a+1] = 1'b1; eRchk[a+1] = 1'b0;
        end
        t = a + 2;
        stalls = 0;
        for (int k = 0; k < nin; k++) begin
            if (t < len) begin
                eBusy[t] = 1'b1; eRdEn[t] = 1'b1; eRaddr[t] = k;
            end
            if (t + rdl < len) eMacEn[t+rdl] = 1'b1;
            u = t + 1;
            while (u - 1 < len && stStall[u-1]) begin
                stalls++;
                if (u < len) begin
                    eBusy[u] = 1'b1; eRaddr[u] = k;
                end
                u++;
            end
            t = u;
        end
        wb = t + rdl + macl;
        for (int j = t; j <= wb && j < len; j++) begin
            eBusy[j] = 1'b1; eRaddr[j] = nin - 1;
        end
        if (wb < len) eWr[wb] = 1'b1;
        for (int j = wb + 1; j < len; j++) begin
            eValid[j] = 1'b1; eRaddr[j] = nin - 1;
        end
        if (wb + 1 < len) begin
            eDone[wb+1] = 1'b1; ePerfChk[wb+1] = 1'b1;
            ePc[wb+1] = wb - a; ePs[wb+1] = stalls;
        end
        doneAt = wb + 1;
    endtask

    task automatic buildModel(input int len, input int nin, input int rdl, input int macl);
        int idleFrom, d;
        idleFrom = 0;
        for (int c = 0; c < len; c++) clearCycle(c);
        for (int c = 0; c < len; c++) begin
            if (stRst[c]) begin
                for (int j = c; j < len; j++) clearCycle(j);
                idleFrom = c + 1;
            end else if (stStart[c] && c >= idleFrom) begin
                schedulePass(c, len, nin, rdl, macl, d);
                idleFrom = d;
            end
        end
    endtask

    task automatic clearTables();
        for (int i = 0; i < MAXC; i++) begin
            stStart[i] = 1'b0; stStall[i] = 1'b0; stRst[i] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int len, input int which);
        sel = which;
        doneCnt = 0; doneCyc = -1; macenCnt = 0; clrCnt = 0; clrCyc = -1;
        wrCyc = -1; firstMacen = -1; obsPc = -1; obsPs = -1;
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            cyc = c;
            chkEn = 1'b1;
            rst_n = !stRst[c];
            start = stStart[c];
            in_stall = stStall[c];
        end
        @(posedge clk); #1;
        chkEn = 1'b0;
        start = 1'b0;
        in_stall = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic resetDut();
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; in_stall = 1'b0;
        #2;
        checkOutput("reset busy", aBusy, 0);
        checkOutput("reset done", aDone, 0);
        checkOutput("reset fc1_raddr", aRaddr, 0);
        checkOutput("reset fc1_rd_en", aRdEn, 0);
        checkOutput("reset mac_clr", aClr, 0);
        checkOutput("reset mac_en", aMacEn, 0);
        checkOutput("reset f6_wr_en", aWr, 0);
        checkOutput("reset f6_valid", aValid, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // Per-cycle comparison of the selected instance against the model, mid-cycle.
    always @(negedge clk) begin
        if (chkEn) begin
            if (sel == 0) begin
                oBusy = aBusy; oDone = aDone; oRaddr = int'(aRaddr); oRdEn = aRdEn;
                oClr = aClr; oMacEn = aMacEn; oWr = aWr; oValid = aValid;
            end else begin
                oBusy = bBusy; oDone = bDone; oRaddr = int'(bRaddr); oRdEn = bRdEn;
                oClr = bClr; oMacEn = bMacEn; oWr = bWr; oValid = bValid;
            end
            checkOutput("busy", oBusy, eBusy[cyc]);
            checkOutput("done", oDone, eDone[cyc]);
            checkOutput("fc1_rd_en", oRdEn, eRdEn[cyc]);
            checkOutput("mac_clr", oClr, eClr[cyc]);
            checkOutput("mac_en", oMacEn, eMacEn[cyc]);
            checkOutput("f6_wr_en", oWr, eWr[cyc]);
            checkOutput("f6_valid", oValid, eValid[cyc]);
            if (eRchk[cyc]) checkOutput("fc1_raddr", oRaddr, eRaddr[cyc]);
`ifdef FC1_PERF_CNT_EN
            if (sel == 0 && ePerfChk[cyc]) begin
                checkOutput("perf_cycles", aPc, ePc[cyc]);
                checkOutput("perf_stalls", aPs, ePs[cyc]);
                obsPc = aPc;
                obsPs = aPs;
            end
`endif
            if (oDone) begin doneCnt++; doneCyc = cyc; end
            if (oMacEn) begin
                macenCnt++;
                if (firstMacen < 0) firstMacen = cyc;
            end
            if (oClr) begin clrCnt++; clrCyc = cyc; end
            if (oWr) wrCyc = cyc;
        end
    end

    initial begin
        // Nominal pass, no stalls.
        resetDut();
        clearTables();
        stStart[0] = 1'b1;
        buildModel(420, 400, 1, 2);
        applyStimulus(420, 0);
        checkOutput("nominal done cycle", doneCyc, 406);
        checkOutput("nominal done count", doneCnt, 1);
        checkOutput("nominal wr cycle", wrCyc, 405);
        checkOutput("nominal mac_en count", macenCnt, 400);
        checkOutput("nominal first mac_en", firstMacen, 3);
        checkOutput("nominal mac_clr cycle", clrCyc, 1);

        // Three stalls at k=100 and one on the final address.
        resetDut();
        clearTables();
        stStart[0] = 1'b1;
        stStall[102] = 1'b1; stStall[103] = 1'b1; stStall[104] = 1'b1;
        stStall[404] = 1'b1;
        buildModel(430, 400, 1, 2);
        applyStimulus(430, 0);
        checkOutput("stall done cycle", doneCyc, 410);
        checkOutput("stall mac_en count", macenCnt, 400);
`ifdef FC1_PERF_CNT_EN
        checkOutput("stall perf_cycles", obsPc, 409);
        checkOutput("stall perf_stalls", obsPs, 4);
`endif

        // Starts while busy are dropped.
        resetDut();
        clearTables();
        stStart[0] = 1'b1; stStart[50] = 1'b1; stStart[405] = 1'b1;
        buildModel(420, 400, 1, 2);
        applyStimulus(420, 0);
        checkOutput("busy-start done cycle", doneCyc, 406);
        checkOutput("busy-start mac_clr count", clrCnt, 1);

        // Start in the done cycle launches a second pass.
        resetDut();
        clearTables();
        stStart[0] = 1'b1; stStart[406] = 1'b1;
        buildModel(830, 400, 1, 2);
        applyStimulus(830, 0);
        checkOutput("b2b mac_clr count", clrCnt, 2);
        checkOutput("b2b second mac_clr", clrCyc, 407);
        checkOutput("b2b done count", doneCnt, 2);
        checkOutput("b2b second done", doneCyc, 812);

        // Reset mid-pass, then a clean pass.
        resetDut();
        clearTables();
        stStart[0] = 1'b1;
        stRst[200] = 1'b1; stRst[201] = 1'b1;
        stStart[210] = 1'b1;
        buildModel(630, 400, 1, 2);
        applyStimulus(630, 0);
        checkOutput("abort done count", doneCnt, 1);
        checkOutput("abort done cycle", doneCyc, 616);

        // Small instance.
        resetDut();
        clearTables();
        stStart[0] = 1'b1;
        buildModel(20, 4, 2, 1);
        applyStimulus(20, 1);
        checkOutput("small done cycle", doneCyc, 10);
        checkOutput("small wr cycle", wrCyc, 9);
        checkOutput("small first mac_en", firstMacen, 4);
        checkOutput("small mac_en count", macenCnt, 4);

        resetDut();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
